// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserializer.
// Optional parity framing is enabled by defining SIPO_PARITY_EN.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Widest word the parity helper covers.
  localparam int unsigned PAR_MAX_W = 64;

  // Counter width able to hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $unsigned($clog2(width + 1));
  endfunction

  // Even parity bit of data (zero-extended words are unaffected).
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and frame bit counter for sipo_deser; pulses frame_done_c on the final frame bit.
// With SIPO_PARITY_EN defined a frame carries one extra (parity) bit that is counted but not shifted.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        si,
  input  logic                        si_valid,
  input  logic                        shift_en,
  output logic [WIDTH-1:0]            word_c,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        busy,
  output logic                        frame_done_c
);

  localparam int unsigned CNTW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = WIDTH;
`endif
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAME_BITS - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift_c;

  assign sr_shift_c   = MSB_FIRST ? {sr[WIDTH-2:0], si} : {si, sr[WIDTH-1:1]};
  assign frame_done_c = si_valid && (bit_cnt == LAST_CNT);

  // Completed word: data is already in sr at the parity edge, otherwise include the final bit.
`ifdef SIPO_PARITY_EN
  assign word_c = sr;
`else
  assign word_c = sr_shift_c;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      sr      <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      if (shift_en) begin
        sr <= sr_shift_c;
      end
      if (frame_done_c) begin
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (si_valid) begin
        bit_cnt <= bit_cnt + CNTW'(1);
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserializer with valid/ready word output and sticky overflow.
// Define SIPO_PARITY_EN for WIDTH+1 bit frames with an even parity bit and a perr output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        si,
  input  logic                        si_valid,
  output logic [WIDTH-1:0]            po,
  output logic                        po_valid,
  input  logic                        po_ready,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        busy,
  output logic                        overflow
`ifdef SIPO_PARITY_EN
  ,
  output logic                        perr
`endif
);

  localparam int unsigned CNTW = cnt_width(WIDTH);
  localparam logic [CNTW-1:0] LAST_DATA_CNT = CNTW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic             shift_en_c;
  logic             frame_done_c;
  logic [WIDTH-1:0] word_c;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk          (clk),
    .clear        (clear),
    .si           (si),
    .si_valid     (si_valid),
    .shift_en     (shift_en_c),
    .word_c       (word_c),
    .bit_cnt      (bit_cnt),
    .busy         (busy),
    .frame_done_c (frame_done_c)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing; the parity bit is counted but kept out of the shift register.
  always_comb begin
    state_d    = state_q;
    shift_en_c = si_valid;
    case (state_q)
      IDLE: begin
        if (si_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (si_valid && (bit_cnt == LAST_DATA_CNT)) begin
`ifdef SIPO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
      PARITY: begin
        shift_en_c = 1'b0;
        if (si_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SIPO_PARITY_EN
  logic perr_c;
  assign perr_c = even_parity(PAR_MAX_W'(word_c)) ^ si;
`endif

  // Output word register: a completion into a stalled, full register is dropped and flagged.
  always_ff @(posedge clk) begin
    if (clear) begin
      po       <= '0;
      po_valid <= 1'b0;
      overflow <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr     <= 1'b0;
`endif
    end else if (frame_done_c) begin
      if (po_valid && !po_ready) begin
        overflow <= 1'b1;
      end else begin
        po       <= word_c;
        po_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        perr     <= perr_c;
`endif
      end
    end else if (po_valid && po_ready) begin
      po_valid <= 1'b0;
    end
  end

endmodule
